mat_cache_loader: RTL

Upstream feeder for the matrix cache. Accepts a matrix as a stream of `WIDTH`-element vectors over a valid/ready handshake and converts each accepted vector into one row or column write command for a selected cache slot. It can optionally append a single in-place transpose command. It signals completion so the sequencer can start diagonal reads.

---
 rtl/mat_pkg.sv | 30 +++
 rtl/mat_cache_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mat_pkg.sv
// Shared matrix-cache types: write/read command encodings and the loader state set.
// Latency: n/a (types only).
// Backpressure: n/a.
package mat_pkg;

    // Single-precision element carried as its raw IEEE-754 bit pattern.
    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        WOP_DISABLE   = 2'd0,
        WOP_ROW       = 2'd1,
        WOP_COL       = 2'd2,
        WOP_TRANSPOSE = 2'd3
    } MatCacheWriteOp_t;

    typedef enum logic [1:0] {
        ROP_DISABLE = 2'd0,
        ROP_ROW     = 2'd1,
        ROP_COL     = 2'd2,
        ROP_DIAG    = 2'd3
    } MatCacheReadOp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_TRANSPOSE = 2'd2,
        ST_DONE      = 2'd3
    } MatLoaderState_t;

endpackage

// File: rtl/mat_cache_loader.sv
// Turns a stream of WIDTH-element vectors into row/column write commands for one cache slot, optionally followed by a transpose.
// Latency: a beat at edge E presents its command during cycle E+1; done pulses on the cycle of the final command.
// Backpressure: in_ready is high only in LOAD (one vector per cycle); abort cancels a load without a done pulse.
module mat_cache_loader
    import mat_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CACHE_ADDR_SIZE-1:0]  start_addr,
    input  logic                        start_col,
    input  logic                        start_transpose,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  fp32_t [WIDTH-1:0]           in_data,
    output MatCacheWriteOp_t            write_op,
    output logic [CACHE_ADDR_SIZE-1:0]  write_addr1,
    output logic [CACHE_ADDR_SIZE-1:0]  write_addr2,
    output logic [WIDTH_ADDR_SIZE-1:0]  write_param,
    output fp32_t [WIDTH-1:0]           write_data
);

    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX = WIDTH_ADDR_SIZE'(WIDTH - 1);

    MatLoaderState_t              state_q, state_d;
    logic [WIDTH_ADDR_SIZE-1:0]   idx_q, idx_d;
    logic [CACHE_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic                         col_q, col_d;
    logic                         tp_q, tp_d;
    MatCacheWriteOp_t             wop_q, wop_d;
    logic [WIDTH_ADDR_SIZE-1:0]   wparam_q, wparam_d;
    fp32_t [WIDTH-1:0]            wdata_q, wdata_d;

    // Moore status outputs decoded from the state; both write addresses track the latched slot.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign in_ready    = (state_q == ST_LOAD);
    assign write_op    = wop_q;
    assign write_addr1 = addr_q;
    assign write_addr2 = addr_q;
    assign write_param = wparam_q;
    assign write_data  = wdata_q;

    // Next-state and next-command logic; write_op falls back to DISABLE unless a command is due.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        col_d    = col_q;
        tp_d     = tp_q;
        wop_d    = WOP_DISABLE;
        wparam_d = wparam_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    col_d   = start_col;
                    tp_d    = start_transpose;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Abort wins over a coincident beat, so that beat is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    wop_d    = col_q ? WOP_COL : WOP_ROW;
                    wparam_d = idx_q;
                    wdata_d  = in_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = tp_q ? ST_TRANSPOSE : ST_DONE;
                    end else begin
                        idx_d = idx_q + WIDTH_ADDR_SIZE'(1);
                    end
                end
            end
            ST_TRANSPOSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wop_d   = WOP_TRANSPOSE;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched load parameters and registered write command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            col_q    <= 1'b0;
            tp_q     <= 1'b0;
            wop_q    <= WOP_DISABLE;
            wparam_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            tp_q     <= tp_d;
            wop_q    <= wop_d;
            wparam_q <= wparam_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule
